// File: rtl/opcodes_pkg.sv
// Shared opcode, funct and state definitions for the multi-cycle decoder.
// Pure declarations: no latency, no flow control.
package opcodes_pkg;

  localparam logic [6:0] RALU     = 7'b0110011;
  localparam logic [6:0] IALU     = 7'b0010011;
  localparam logic [6:0] SBBRANCH = 7'b1100011;
  localparam logic [6:0] IJUMP    = 7'b1100111;
  localparam logic [6:0] UJJUMP   = 7'b1101111;
  localparam logic [6:0] ILOAD    = 7'b0000011;
  localparam logic [6:0] SSTORE   = 7'b0100011;

  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_EXEC = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } mc_state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == ILOAD) || (opc == SSTORE);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Maps opcode/funct3/funct7 to ALU select, immediate and shift-immediate flags.
// Purely combinational, zero latency, no flow control.
module alu_decode
  import opcodes_pkg::*;
#(
  parameter int ENABLE_M = 0,
  localparam int ALUOP_W = 4 + ENABLE_M
) (
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  output logic [ALUOP_W-1:0] aluop,
  output logic               imm,
  output logic               shifti
);

  always_comb begin
    aluop  = '0;
    imm    = 1'b0;
    shifti = 1'b0;
    case (opcode)
      RALU: begin
        aluop[3:0] = {funct3, funct7[5]};
        // The M-extension select bit only exists when the ALU is built with it.
        if (ENABLE_M != 0 && funct7 == F7_MULDIV) aluop[ALUOP_W-1] = 1'b1;
      end
      IALU: begin
        imm = 1'b1;
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          aluop[3:0] = {funct3, funct7[5]};
          shifti     = 1'b1;
        end else begin
          aluop[3:0] = {funct3, 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_decoder.sv
// Multi-cycle RV32 decoder: single-cycle ALU/branch/jump, loads/stores sequenced via mem_req/mem_ready.
// Latency: 1 cycle for ALU/branch/jump, >=2 for memory ops; PC is held (incr=0) until memory responds or times out.
module mc_decoder
  import opcodes_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int LOAD_WB_STAGE = 1,
  parameter int ENABLE_M      = 0,
  localparam int ALUOP_W      = 4 + ENABLE_M
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [31:0]        instr,
  input  logic               brnch,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] AluOp,
  output logic               regw,
  output logic               incr,
  output logic               imm,
  output logic               shifti,
  output logic               mem_req,
  output logic               mem_we,
  output logic [2:0]         mem_size,
  output logic [1:0]         wb_sel,
  output logic               illegal,
  output logic               fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  mc_state_t          state, state_nxt;
  logic               lat_we;
  logic [2:0]         lat_size;
  logic [CNT_W-1:0]   cnt;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_imm, dec_shifti;
  logic               timeout_hit;
  wb_sel_t            wb_sel_e;
  logic               unused_instr_bits;

  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  alu_decode #(.ENABLE_M(ENABLE_M)) u_alu_decode (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .aluop  (dec_aluop),
    .imm    (dec_imm),
    .shifti (dec_shifti)
  );

  // Ready in the same cycle as the last allowed wait wins over the timeout.
  assign timeout_hit = TO_EN && !mem_ready && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    AluOp     = '0;
    regw      = 1'b0;
    incr      = 1'b0;
    imm       = 1'b0;
    shifti    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 3'b000;
    wb_sel_e  = WB_ALU;
    illegal   = 1'b0;
    fault     = 1'b0;
    // Outputs are forced low for the whole reset window, not just after an edge.
    if (nreset) begin
      case (state)
        ST_EXEC: begin
          incr = 1'b1;
          case (instr[6:0])
            RALU, IALU: begin
              AluOp  = dec_aluop;
              imm    = dec_imm;
              shifti = dec_shifti;
              regw   = 1'b1;
            end
            SBBRANCH: incr = !brnch;
            IJUMP, UJJUMP: begin
              regw     = 1'b1;
              wb_sel_e = WB_PC4;
            end
            ILOAD, SSTORE: begin
              mem_req   = 1'b1;
              incr      = 1'b0;
              mem_we    = (instr[6:0] == SSTORE);
              state_nxt = ST_MEM;
            end
            default: illegal = 1'b1;
          endcase
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_we   = lat_we;
          mem_size = lat_size;
          if (mem_ready) begin
            if (lat_we) begin
              incr      = 1'b1;
              state_nxt = ST_EXEC;
            end else if (LOAD_WB_STAGE != 0) begin
              state_nxt = ST_WB;
            end else begin
              regw      = 1'b1;
              wb_sel_e  = WB_MEM;
              incr      = 1'b1;
              state_nxt = ST_EXEC;
            end
          end else if (timeout_hit) begin
            fault     = 1'b1;
            incr      = 1'b1;
            state_nxt = ST_EXEC;
          end
        end
        ST_WB: begin
          regw      = 1'b1;
          wb_sel_e  = WB_MEM;
          incr      = 1'b1;
          state_nxt = ST_EXEC;
        end
        default: state_nxt = ST_EXEC;
      endcase
    end
  end

  assign wb_sel = wb_sel_e;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_EXEC;
      lat_we   <= 1'b0;
      lat_size <= 3'b000;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_EXEC && is_mem_op(instr[6:0])) begin
        lat_we   <= (instr[6:0] == SSTORE);
        lat_size <= instr[14:12];
        cnt      <= '0;
      end else if (state == ST_MEM && !mem_ready && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_decoder.sv
// Scoreboard bench for mc_decoder: two instances (timeout=4/WB stage/no M and timeout off/no WB stage/M).
module tb_mc_decoder;

  typedef struct packed {
    logic [4:0] alu;
    logic       regw, incr, imm, shifti, mreq, mwe;
    logic [2:0] msz;
    logic [1:0] wb;
    logic       ill, flt;
  } outs_t;

  typedef struct {
    outs_t o1;
    outs_t o2;
    logic  chk2;
    string tag;
  } sb_t;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        brnch = 1'b0;
  logic        mem_ready = 1'b0;

  logic [3:0] aluop1;
  logic [4:0] aluop2;
  logic       regw1, incr1, imm1, shifti1, mreq1, mwe1, ill1, flt1;
  logic       regw2, incr2, imm2, shifti2, mreq2, mwe2, ill2, flt2;
  logic [2:0] msz1, msz2;
  logic [1:0] wb1, wb2;
  outs_t      obs1, obs2;

  sb_t sb[$];
  int  compared = 0;
  int  mismatched = 0;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_SB   = 32'h00208023;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  always #5 clock = ~clock;

  mc_decoder #(.MEM_TIMEOUT(4), .LOAD_WB_STAGE(1), .ENABLE_M(0)) dut (
    .clock(clock), .nreset(nreset), .instr(instr), .brnch(brnch), .mem_ready(mem_ready),
    .AluOp(aluop1), .regw(regw1), .incr(incr1), .imm(imm1), .shifti(shifti1),
    .mem_req(mreq1), .mem_we(mwe1), .mem_size(msz1), .wb_sel(wb1),
    .illegal(ill1), .fault(flt1)
  );

  mc_decoder #(.MEM_TIMEOUT(0), .LOAD_WB_STAGE(0), .ENABLE_M(1)) dut2 (
    .clock(clock), .nreset(nreset), .instr(instr), .brnch(brnch), .mem_ready(mem_ready),
    .AluOp(aluop2), .regw(regw2), .incr(incr2), .imm(imm2), .shifti(shifti2),
    .mem_req(mreq2), .mem_we(mwe2), .mem_size(msz2), .wb_sel(wb2),
    .illegal(ill2), .fault(flt2)
  );

  assign obs1 = {1'b0, aluop1, regw1, incr1, imm1, shifti1, mreq1, mwe1, msz1, wb1, ill1, flt1};
  assign obs2 = {aluop2, regw2, incr2, imm2, shifti2, mreq2, mwe2, msz2, wb2, ill2, flt2};

  function automatic outs_t mk(input logic [4:0] alu, input logic regw, input logic incr,
                               input logic imm, input logic shifti, input logic mreq,
                               input logic mwe, input logic [2:0] msz, input logic [1:0] wb,
                               input logic ill, input logic flt);
    return {alu, regw, incr, imm, shifti, mreq, mwe, msz, wb, ill, flt};
  endfunction

  // Frequently used expected output vectors.
  outs_t E_ZERO, E_ADD, E_LDREQ, E_LDWAIT, E_WB, E_LDDONE, E_ILL;
  initial begin
    E_ZERO   = '0;
    E_ADD    = mk(5'b00000, 1, 1, 0, 0, 0, 0, 3'b000, 2'd0, 0, 0);
    E_LDREQ  = mk(5'b00000, 0, 0, 0, 0, 1, 0, 3'b000, 2'd0, 0, 0);
    E_LDWAIT = mk(5'b00000, 0, 0, 0, 0, 1, 0, 3'b010, 2'd0, 0, 0);
    E_WB     = mk(5'b00000, 1, 1, 0, 0, 0, 0, 3'b000, 2'd1, 0, 0);
    E_LDDONE = mk(5'b00000, 1, 1, 0, 0, 1, 0, 3'b010, 2'd1, 0, 0);
    E_ILL    = mk(5'b00000, 0, 1, 0, 0, 0, 0, 3'b000, 2'd0, 1, 0);
  end

  task automatic drive(input logic [31:0] i, input logic b, input logic r, input logic rst,
                       input outs_t e1, input outs_t e2, input logic c2, input string tag);
    sb_t ent;
    @(negedge clock);
    instr = i; brnch = b; mem_ready = r; nreset = rst;
    ent.o1 = e1; ent.o2 = e2; ent.chk2 = c2; ent.tag = tag;
    sb.push_back(ent);
  endtask

  task automatic do_reset();
    @(negedge clock);
    nreset = 1'b0; mem_ready = 1'b0; brnch = 1'b0; instr = I_ADD;
    @(negedge clock);
  endtask

  task automatic test_reset();
    sb_t ent;
    for (int k = 0; k < 2; k++) begin
      case (k)
        0: drive(I_ADD, 0, 0, 0, E_ZERO, E_ZERO, 1, "reset_add");
        default: drive(I_LW, 0, 1, 0, E_ZERO, E_ZERO, 1, "reset_lw");
      endcase
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  task automatic test_alu();
    sb_t ent;
    for (int k = 0; k < 11; k++) begin
      case (k)
        0: drive(I_ADD, 0, 0, 1, E_ADD, E_ADD, 1, "add");
        1: drive(32'h403100B3, 0, 0, 1, mk(5'b00001, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0),
                 mk(5'b00001, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "sub");
        2: drive(32'h4030D093, 0, 0, 1, mk(5'b01011, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0),
                 mk(5'b01011, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1, "srai");
        3: drive(32'h00309093, 0, 0, 1, mk(5'b00010, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0),
                 mk(5'b00010, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1, "slli");
        4: drive(32'hFFF08093, 0, 1, 1, mk(5'b00000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0),
                 mk(5'b00000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, "addi_neg");
        5: drive(32'h02208033, 0, 0, 1, E_ADD,
                 mk(5'b10000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "mul");
        6: drive(32'h00208463, 1, 0, 1, E_ZERO, E_ZERO, 1, "beq_taken");
        7: drive(32'h00208463, 0, 0, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
                 mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "beq_not_taken");
        8: drive(32'h0080006F, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 0, 0),
                 mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 0, 0), 1, "jal");
        9: drive(32'h000080E7, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 0, 0),
                 mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 0, 0), 1, "jalr");
        default: drive(I_ILL, 0, 0, 1, E_ILL, E_ILL, 1, "illegal");
      endcase
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  // lw, ready on the 3rd MEM cycle; instr changes to a store while in MEM.
  task automatic test_lw();
    sb_t ent;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drive(I_LW, 0, 0, 1, E_LDREQ, E_LDREQ, 1, "lw_exec");
        1: drive(I_SB, 0, 0, 1, E_LDWAIT, E_LDWAIT, 1, "lw_mem1");
        2: drive(I_SB, 0, 0, 1, E_LDWAIT, E_LDWAIT, 1, "lw_mem2");
        3: drive(I_SB, 0, 1, 1, E_LDWAIT, E_LDDONE, 1, "lw_mem3_ready");
        4: drive(I_ADD, 0, 0, 1, E_WB, E_ADD, 1, "lw_wb");
        default: drive(I_ADD, 0, 0, 1, E_ADD, E_ADD, 1, "lw_next");
      endcase
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t ent;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: drive(I_LW, 0, 0, 1, E_LDREQ, E_ZERO, 0, "b2b_exec1");
        1: drive(I_LW, 0, 1, 1, E_LDWAIT, E_ZERO, 0, "b2b_mem1");
        2: drive(I_LW, 0, 0, 1, E_WB, E_ZERO, 0, "b2b_wb1");
        3: drive(I_LW, 0, 0, 1, E_LDREQ, E_ZERO, 0, "b2b_exec2");
        4: drive(I_LW, 0, 1, 1, E_LDWAIT, E_ZERO, 0, "b2b_mem2");
        5: drive(I_ADD, 0, 0, 1, E_WB, E_ZERO, 0, "b2b_wb2");
        default: drive(I_ADD, 0, 0, 1, E_ADD, E_ZERO, 0, "b2b_next");
      endcase
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  // Store with ready already high in EXEC (ignored there) and in the 1st MEM cycle.
  task automatic test_sw();
    sb_t ent;
    outs_t e_req, e_done;
    e_req  = mk(0, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0);
    e_done = mk(0, 0, 1, 0, 0, 1, 1, 3'b010, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(I_SW, 0, 1, 1, e_req, e_req, 1, "sw_exec");
        1: drive(I_ADD, 0, 1, 1, e_done, e_done, 1, "sw_mem_ready");
        default: drive(I_ADD, 0, 0, 1, E_ADD, E_ADD, 1, "sw_next");
      endcase
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  // ready_at: MEM cycle (1-based) where ready rises, 0 = never.
  task automatic test_timeout(input int ready_at);
    sb_t ent;
    outs_t e_fault;
    e_fault = mk(0, 0, 1, 0, 0, 1, 0, 3'b010, 0, 0, 1);
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0)
        drive(I_LW, 0, 0, 1, E_LDREQ, E_LDREQ, 1, "to_exec");
      else if (k < 4)
        drive(I_LW, 0, 0, 1, E_LDWAIT, E_LDWAIT, 1, $sformatf("to_mem%0d", k));
      else if (k == 4 && ready_at == 4)
        drive(I_LW, 0, 1, 1, E_LDWAIT, E_LDDONE, 1, "to_mem4_ready");
      else if (k == 4)
        drive(I_LW, 0, 0, 1, e_fault, E_LDWAIT, 1, "to_mem4_fault");
      else if (k == 5 && ready_at == 4)
        drive(I_ADD, 0, 0, 1, E_WB, E_ADD, 1, "to_wb");
      else if (k == 5)
        drive(I_ADD, 0, 0, 1, E_ADD, E_LDWAIT, 1, "to_after_fault");
      else
        drive(I_ADD, 0, 0, 1, E_ADD, E_ZERO, (ready_at == 4), "to_next");
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (ready_at == 4 && k == 6) ent.o2 = E_ADD;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  task automatic test_reset_mem();
    sb_t ent;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(I_LW, 0, 0, 1, E_LDREQ, E_LDREQ, 1, "rm_exec");
        1: drive(I_LW, 0, 0, 1, E_LDWAIT, E_LDWAIT, 1, "rm_mem");
        2: drive(I_LW, 0, 0, 0, E_ZERO, E_ZERO, 1, "rm_async_reset");
        3: drive(I_ILL, 0, 0, 1, E_ILL, E_ILL, 1, "rm_illegal");
        default: drive(I_ADD, 0, 0, 1, E_ADD, E_ADD, 1, "rm_add");
      endcase
      #1;
      ent = sb.pop_front();
      compared++;
      if (obs1 !== ent.o1) begin mismatched++; $display("FAIL %s dut1 got=%h want=%h", ent.tag, obs1, ent.o1); end
      if (ent.chk2) begin
        compared++;
        if (obs2 !== ent.o2) begin mismatched++; $display("FAIL %s dut2 got=%h want=%h", ent.tag, obs2, ent.o2); end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_alu();
    test_lw();
    test_back_to_back();
    test_sw();
    test_timeout(0);
    test_timeout(4);
    test_reset_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_decoder.md
# mc_decoder

Multi-cycle RISC-V instruction decoder and control sequencer for the single-issue core.
- Takes the full 32-bit instruction rather than pre-split fields, and decodes R/I ALU ops, branches, jal/jalr, loads and stores.
- Sequences loads and stores over multiple cycles with a memory request/ready handshake, holding the PC (`incr` low) until the access completes.
- Sits between instruction memory and the datapath and drives the ALU, register file write enable, PC increment and data-memory control.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: cycles allowed in MEM without `mem_ready` before a fault; 0 disables the timeout.
- `LOAD_WB_STAGE`, default 1: 1 means load writeback happens in a separate WB cycle; 0 means it happens in the `mem_ready` cycle.
- `ENABLE_M`, default 0: 1 decodes RV32M (`funct7`=0000001) on RALU.
- `ALUOP_W`, derived: 4 + `ENABLE_M`.

Ports:
- `clock`  in  1  core clock; all state updates on the rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `instr`  in  32  current instruction, held stable by the PC while `incr`=0.
- `brnch`  in  1  branch condition true from the datapath comparator.
- `mem_ready`  in  1  data memory has completed the access this cycle.
- `AluOp`  out  `ALUOP_W`  ALU operation select.
- `regw`  out  1  register file write enable.
- `incr`  out  1  1 = PC+4; 0 = hold the PC, or take the branch when in EXEC.
- `imm`  out  1  ALU operand B comes from the immediate.
- `shifti`  out  1  immediate shift (shamt comes from `instr[24:20]`).
- `mem_req`  out  1  data memory request, held until `mem_ready`.
- `mem_we`  out  1  1 = store, 0 = load; valid while `mem_req`=1.
- `mem_size`  out  3  `funct3` of the latched load/store.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = MEM, 2 = PC+4.
- `illegal`  out  1  unknown opcode in EXEC (combinational).
- `fault`  out  1  one-cycle pulse when the memory access times out.

## Operation
- States: EXEC, MEM, WB (held in a state register).
- Reset, while `nreset` is low: state is EXEC, the timeout counter is 0, and the instruction latch is 0. All outputs are 0, including `incr` and `mem_req`.
- EXEC decode:
  - All outputs are decoded from `instr` combinationally.
  - Defaults: `incr`=1, all other outputs 0.
- RALU: `AluOp`={m, funct3, funct7[5]}, where m = `ENABLE_M` & (funct7==0000001) and the m bit is present only when `ENABLE_M`=1. Also `regw`=1.
- IALU:
  - funct3 ∈ {001, 101}: `AluOp`={0, funct3, funct7[5]} and `shifti`=1.
  - Otherwise: `AluOp`={0, funct3, 0}.
  - In both cases `imm`=1 and `regw`=1.
- SBBRANCH: `incr`=!`brnch`.
- IJUMP/UJJUMP: `regw`=1, `wb_sel`=2.
- ILOAD/SSTORE in EXEC:
  - Outputs: `mem_req`=1, `incr`=0, `regw`=0.
  - `mem_we`=1 for a store, 0 for a load.
  - Latch `instr`; next state is MEM.
- MEM: `mem_req`=1, `incr`=0; `mem_we` and `mem_size` come from the latched instruction.
  - `mem_ready`=1 on a store: `incr`=1, next state EXEC.
  - `mem_ready`=1 on a load with `LOAD_WB_STAGE`=1: next state WB.
  - `mem_ready`=1 on a load with `LOAD_WB_STAGE`=0: `regw`=1, `wb_sel`=1, `incr`=1, next state EXEC.
  - No ready and counter==`MEM_TIMEOUT`-1: `fault`=1, `mem_req` still 1 this cycle, `incr`=1 (the instruction is skipped), no `regw`, next state EXEC.
- WB: `regw`=1, `wb_sel`=1, `incr`=1, next state EXEC.
- Illegal opcode: `illegal`=1, `incr`=1, no other side effects; state stays EXEC.

## Timing
- Latency, EXEC-cycle count:
  - ALU, branch and jump instructions: 1 cycle.
  - Store: 1 + wait cycles, minimum 2.
  - Load: minimum 3 with `LOAD_WB_STAGE`=1, minimum 2 with `LOAD_WB_STAGE`=0.
- `mem_ready` is ignored outside MEM.
- `mem_ready` and the timeout in the same cycle: ready wins, and no fault is raised.
- Timeout counter: cleared on entry to MEM, increments on each MEM cycle without ready, and saturates.
- `nreset` asserted mid-MEM: `mem_req` drops immediately (asynchronously); on release the block is in EXEC.
- `instr` changes while in MEM/WB have no effect (the latched copy is used).
- Back-to-back loads: EXEC follows WB, and the next `mem_req` rises in that EXEC cycle.

## Structure
- Package `opcodes_pkg`:
  - Opcode constants (RALU, IALU, SBBRANCH, IJUMP, UJJUMP, ILOAD, SSTORE).
  - State enum `mc_state_t`.
  - Enum `wb_sel_t` (ALU/MEM/PC4).
  - funct3 shift codes.
- Sub-module `alu_decode`: combinational mapping of opcode/funct3/funct7 to `AluOp`, `imm`, `shifti`, parametrised by `ENABLE_M`.
- `mc_decoder` holds the FSM, the instruction latch and the timeout counter.

## Test plan
- add x1,x2,x3 (0x003100B3): `AluOp`=0000, `regw`=1, `incr`=1, `imm`=0, in a single cycle.
- srai x1,x1,3 (0x4030D093): `AluOp`=1011, `shifti`=1, `imm`=1. Then slli (0x00309093): `AluOp`=0010, `shifti`=1.
- lw with `mem_ready` high on the 3rd MEM cycle, `LOAD_WB_STAGE`=1:
  - `mem_req` is high for 4 cycles and `incr`=0 for 4 cycles.
  - WB then has `regw`=1, `wb_sel`=1, `incr`=1.
- sw with ready in the 1st MEM cycle: `mem_we`=1, `mem_size`=010, `incr` sequence 0,1, `regw` never 1.
- Timeouts, lw with `MEM_TIMEOUT`=4 and `mem_ready` held low:
  - `fault` pulses in the 4th MEM cycle, `regw`=0, then EXEC.
  - With ready in that same cycle instead, no fault.
- `nreset` low during MEM: `mem_req`=0 immediately. Then an illegal opcode 0x0000007F: `illegal`=1, `incr`=1, `regw`=0.
